debug_halt_ctrl: RTL and testbench
==================================

# debug_halt_ctrl

Sequences debug-mode entry and exit for the Aquila core. Sits between the Debug Module/CSR file and `pipeline_control`. It waits for an instruction boundary in Execute and then issues the one-cycle `debug_halt_req_o` pulse that flushes Fetch/Decode. The same pulse redirects the PCU to the halt address. It also captures `dpc` and the `dcsr.cause` code, tracks debug mode, and handles `dret` and single-step.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `HALT_ADDR`, 32'h0000_0800, debug ROM entry address.
- `HALT_TIMEOUT`, 255, WAIT_BOUNDARY cycles before `halt_timeout_o` is raised.

Ports:
- `clk_i` input 1: the single clock.
- `rst_ni` input 1: reset, asynchronous and active-low.
- `haltreq_i` input 1: level halt request from the Debug Module.
- `ebreak_i` input 1: `ebreak` in Execute with `dcsr.ebreakm` = 1.
- `step_i` input 1: `dcsr.step`.
- `dret_i` input 1: `dret` in Execute (debug mode only).
- `exe_valid_i` input 1: Execute holds a valid instruction.
- `exe_stall_i` input 1: pipeline stalled (load hazard or memory wait).
- `exe_flush_i` input 1: Execute is being flushed this cycle.
- `exe_pc_i` input XLEN: PC of the Execute instruction.
- `exe_npc_i` input XLEN: resolved next PC of the Execute instruction.
- `debug_halt_req_o` output 1: one-cycle pulse to `pipeline_control` and the PCU.
- `halt_addr_o` output XLEN: constant `HALT_ADDR`.
- `dpc_o` output XLEN: captured `dpc`.
- `dpc_we_o` output 1: CSR-file write strobe for `dpc` and `dcsr.cause`.
- `cause_o` output 3: 1 = ebreak, 3 = haltreq, 4 = step.
- `debug_mode_o` output 1: the hart is in debug mode.
- `resumeack_o` output 1: one-cycle pulse when debug mode is left.
- `halt_timeout_o` output 1: sticky; no boundary was found within `HALT_TIMEOUT` cycles.

## Operation
- **Boundary.** A boundary is `exe_valid_i & !exe_stall_i & !exe_flush_i`.
- **States:** RUN, WAIT_BND, ENTER, DEBUG, RESUME, STEP.
- **RUN:**
  - Boundary with `ebreak_i`: latch `dpc` = `exe_pc_i`, cause = 1, go to ENTER.
  - Otherwise, `haltreq_i`: go to WAIT_BND with cause = 3.
  - `ebreak_i` wins over `haltreq_i` in the same cycle.
- **WAIT_BND:**
  - At a boundary: `dpc` = `exe_npc_i`, except `dpc` = `exe_pc_i` if `ebreak_i` (then cause = 1). Go to ENTER.
  - `haltreq_i` deasserting here does not cancel the halt.
  - An 8-bit saturating counter increments each cycle in WAIT_BND. `halt_timeout_o` is set when the count reaches `HALT_TIMEOUT` and cleared on ENTER.
- **ENTER** (exactly 1 cycle): `debug_halt_req_o` = 1 and `dpc_we_o` = 1, then go to DEBUG.
- **DEBUG:**
  - `debug_mode_o` = 1.
  - `haltreq_i`, `ebreak_i` and `step_i` are ignored.
  - `dret_i` at a boundary goes to RESUME.
- **RESUME** (1 cycle): `resumeack_o` = 1. Then:
  - go to STEP if `step_i`;
  - else go to WAIT_BND if `haltreq_i` is still high, with cause = 3;
  - else go to RUN.
- **STEP:**
  - The first boundary retires one instruction. Latch `dpc` = `exe_npc_i` and go to ENTER with cause = 4.
  - Cause priority at that boundary: `ebreak_i` (1) > `haltreq_i` (3) > step (4).
  - If `ebreak_i`, `dpc` = `exe_pc_i`.
- **Outputs.** `debug_halt_req_o`, `dpc_we_o` and `resumeack_o` are pure state decodes, so they have no combinational path from the inputs.
- **Registers.** `dpc_o` and `cause_o` are registers that hold until the next capture.

## Timing
- **Reset values:**
  - state RUN;
  - `dpc_o` 0, `cause_o` 0, counter 0;
  - `debug_halt_req_o`, `dpc_we_o`, `debug_mode_o`, `resumeack_o` and `halt_timeout_o` all 0;
  - `halt_addr_o` = `HALT_ADDR` always.
- **Mid-operation reset.** Reset asserted in any state returns immediately to RUN with the reset values. No pulse is emitted.
- **`ebreak` latency.** Boundary with `ebreak` at cycle N: `debug_halt_req_o` is high at N+1, and `debug_mode_o` is high from N+2.
- **`haltreq` latency.** `haltreq_i` sampled in RUN at N: WAIT_BND at N+1. The earliest pulse is at N+2, if N+1 is a boundary.
- **`dret` latency.** Boundary with `dret_i` at N: `resumeack_o` is high at N+1, and `debug_mode_o` drops at N+2.
- **Pulse widths.** Every pulse lasts exactly one cycle and never repeats without a new trigger.
- **Flush during WAIT_BND.** A flushed Execute instruction is never taken as the boundary. The controller waits for the next valid one.
- **Counter.** Saturates at 255 and does not wrap.

## Test plan
- **Halt request.** `haltreq_i` rises at cycle 10. Cycle 11 is a boundary with `exe_npc_i` = 0x104. Required: pulse at cycle 12, `dpc_o` = 0x104, `cause_o` = 3, `debug_mode_o` = 1 at cycle 13.
- **`ebreak`.** Boundary with `ebreak_i` and `exe_pc_i` = 0x200, with `haltreq_i` high in the same cycle. Required: next cycle pulse, `dpc_o` = 0x200, `cause_o` = 1.
- **Stalled halt.** `haltreq_i` with `exe_stall_i` held for 300 cycles. Required: `halt_timeout_o` rises after 255 cycles. When the stall releases, the pulse occurs and `halt_timeout_o` clears.
- **Single step.** In DEBUG with `step_i` = 1, assert `dret_i`. Then one instruction reaches a boundary with `exe_npc_i` = 0x308. Required: `resumeack_o` pulse, then a pulse with `cause_o` = 4 and `dpc_o` = 0x308.
- **Flush skip.** In WAIT_BND, the first valid cycle has `exe_flush_i` = 1. Required: no pulse. The following unflushed boundary triggers the halt.
- **Mid-operation reset.** `rst_ni` is pulled low while in ENTER or DEBUG. Required: all outputs return to their reset values asynchronously, and the next `haltreq_i` is handled normally.

Source files
------------

// File: rtl/debug_halt_ctrl.sv
// Debug-mode entry/exit sequencer: waits for an Execute instruction boundary, issues the
// halt pulse, captures dpc/cause, and handles dret and single-step.
module debug_halt_ctrl #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] HALT_ADDR    = 'h0000_0800,
    parameter int unsigned     HALT_TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            haltreq_i,
    input  logic            ebreak_i,
    input  logic            step_i,
    input  logic            dret_i,
    input  logic            exe_valid_i,
    input  logic            exe_stall_i,
    input  logic            exe_flush_i,
    input  logic [XLEN-1:0] exe_pc_i,
    input  logic [XLEN-1:0] exe_npc_i,
    output logic            debug_halt_req_o,
    output logic [XLEN-1:0] halt_addr_o,
    output logic [XLEN-1:0] dpc_o,
    output logic            dpc_we_o,
    output logic [2:0]      cause_o,
    output logic            debug_mode_o,
    output logic            resumeack_o,
    output logic            halt_timeout_o
);

    localparam logic [2:0] CauseEbreak  = 3'd1;
    localparam logic [2:0] CauseHaltreq = 3'd3;
    localparam logic [2:0] CauseStep    = 3'd4;

    typedef enum logic [2:0] {
        StRun,
        StWaitBnd,
        StEnter,
        StDebug,
        StResume,
        StStep
    } state_e;

    state_e          state_q;
    logic [XLEN-1:0] dpc_q;
    logic [2:0]      cause_q;
    logic [7:0]      cnt_q;
    logic            timeout_q;
    logic            boundary;

    assign boundary = exe_valid_i & ~exe_stall_i & ~exe_flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StRun;
            dpc_q     <= '0;
            cause_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            // The wait counter only measures the current WAIT_BND residency.
            if (state_q != StWaitBnd) begin
                cnt_q <= '0;
            end
            case (state_q)
                StRun: begin
                    if (boundary && ebreak_i) begin
                        dpc_q   <= exe_pc_i;
                        cause_q <= CauseEbreak;
                        state_q <= StEnter;
                    end else if (haltreq_i) begin
                        cause_q <= CauseHaltreq;
                        state_q <= StWaitBnd;
                    end
                end
                StWaitBnd: begin
                    if (cnt_q != 8'hFF) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                    if (boundary) begin
                        dpc_q     <= ebreak_i ? exe_pc_i : exe_npc_i;
                        cause_q   <= ebreak_i ? CauseEbreak : CauseHaltreq;
                        timeout_q <= 1'b0;
                        state_q   <= StEnter;
                    end else if ((32'(cnt_q) + 32'd1) >= HALT_TIMEOUT) begin
                        timeout_q <= 1'b1;
                    end
                end
                StEnter: begin
                    state_q <= StDebug;
                end
                StDebug: begin
                    if (boundary && dret_i) begin
                        state_q <= StResume;
                    end
                end
                StResume: begin
                    if (step_i) begin
                        state_q <= StStep;
                    end else if (haltreq_i) begin
                        cause_q <= CauseHaltreq;
                        state_q <= StWaitBnd;
                    end else begin
                        state_q <= StRun;
                    end
                end
                StStep: begin
                    if (boundary) begin
                        dpc_q   <= ebreak_i ? exe_pc_i : exe_npc_i;
                        cause_q <= ebreak_i ? CauseEbreak :
                                   haltreq_i ? CauseHaltreq : CauseStep;
                        state_q <= StEnter;
                    end
                end
                default: begin
                    state_q <= StRun;
                end
            endcase
        end
    end

    assign debug_halt_req_o = (state_q == StEnter);
    assign dpc_we_o         = (state_q == StEnter);
    assign resumeack_o      = (state_q == StResume);
    assign debug_mode_o     = (state_q == StDebug) || (state_q == StResume);
    assign halt_addr_o      = HALT_ADDR;
    assign dpc_o            = dpc_q;
    assign cause_o          = cause_q;
    assign halt_timeout_o   = timeout_q;

endmodule

// File: tb/tb_debug_halt_ctrl.sv
// Directed bench for debug_halt_ctrl: each task drives a scenario and checks outputs
// one time unit after the rising edge.
module tb_debug_halt_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        haltreq, ebreak, step, dret;
    logic        exe_valid, exe_stall, exe_flush;
    logic [31:0] exe_pc, exe_npc;
    logic        debug_halt_req, dpc_we, debug_mode, resumeack, halt_timeout;
    logic [31:0] halt_addr, dpc;
    logic [2:0]  cause;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    debug_halt_ctrl dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .haltreq_i        (haltreq),
        .ebreak_i         (ebreak),
        .step_i           (step),
        .dret_i           (dret),
        .exe_valid_i      (exe_valid),
        .exe_stall_i      (exe_stall),
        .exe_flush_i      (exe_flush),
        .exe_pc_i         (exe_pc),
        .exe_npc_i        (exe_npc),
        .debug_halt_req_o (debug_halt_req),
        .halt_addr_o      (halt_addr),
        .dpc_o            (dpc),
        .dpc_we_o         (dpc_we),
        .cause_o          (cause),
        .debug_mode_o     (debug_mode),
        .resumeack_o      (resumeack),
        .halt_timeout_o   (halt_timeout)
    );

    task automatic idle();
        haltreq = 0; ebreak = 0; step = 0; dret = 0;
        exe_valid = 0; exe_stall = 0; exe_flush = 0;
        exe_pc = 32'h0; exe_npc = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        #3;
        total++;
        if ({debug_halt_req, dpc_we, debug_mode, resumeack, halt_timeout} !== 5'b0 ||
            dpc !== 32'h0 || cause !== 3'd0)
            $display("FAIL reset_outputs: got req%b we%b dm%b ra%b to%b dpc=%h cause=%0d, want all 0",
                     debug_halt_req, dpc_we, debug_mode, resumeack, halt_timeout, dpc, cause);
        else passed++;
        total++;
        if (halt_addr !== 32'h800) $display("FAIL halt_addr: got %h want 00000800", halt_addr);
        else passed++;
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    // Leave debug mode through a plain dret with no step/haltreq.
    task automatic exit_debug();
        idle(); exe_valid = 1; dret = 1;
        tick();
        idle();
        tick();
    endtask

    task automatic test_haltreq();
        idle(); haltreq = 1;
        tick();
        total++;
        if (debug_halt_req !== 1'b0) $display("FAIL hr_no_early_pulse: got %b want 0", debug_halt_req);
        else passed++;
        exe_valid = 1; exe_pc = 32'h100; exe_npc = 32'h104;
        tick();
        total++;
        if (debug_halt_req !== 1'b1 || dpc_we !== 1'b1 || dpc !== 32'h104 || cause !== 3'd3 ||
            debug_mode !== 1'b0)
            $display("FAIL hr_enter: got req%b we%b dpc=%h cause=%0d dm%b want 1 1 104 3 0",
                     debug_halt_req, dpc_we, dpc, cause, debug_mode);
        else passed++;
        idle();
        tick();
        total++;
        if (debug_halt_req !== 1'b0 || dpc_we !== 1'b0 || debug_mode !== 1'b1)
            $display("FAIL hr_debug: got req%b we%b dm%b want 0 0 1", debug_halt_req, dpc_we, debug_mode);
        else passed++;
        exe_valid = 1; dret = 1;
        tick();
        total++;
        if (resumeack !== 1'b1 || debug_mode !== 1'b1)
            $display("FAIL dret_resume: got ra%b dm%b want 1 1", resumeack, debug_mode);
        else passed++;
        idle();
        tick();
        total++;
        if (resumeack !== 1'b0 || debug_mode !== 1'b0 || debug_halt_req !== 1'b0)
            $display("FAIL dret_run: got ra%b dm%b req%b want 0 0 0", resumeack, debug_mode, debug_halt_req);
        else passed++;
    endtask

    task automatic test_ebreak();
        idle(); exe_valid = 1; ebreak = 1; haltreq = 1; exe_pc = 32'h200; exe_npc = 32'h204;
        tick();
        total++;
        if (debug_halt_req !== 1'b1 || dpc !== 32'h200 || cause !== 3'd1)
            $display("FAIL ebreak_enter: got req%b dpc=%h cause=%0d want 1 200 1",
                     debug_halt_req, dpc, cause);
        else passed++;
        idle();
        tick();
        total++;
        if (debug_mode !== 1'b1 || debug_halt_req !== 1'b0)
            $display("FAIL ebreak_debug: got dm%b req%b want 1 0", debug_mode, debug_halt_req);
        else passed++;
        // Triggers are ignored while in debug mode.
        exe_valid = 1; haltreq = 1; ebreak = 1; step = 1; exe_pc = 32'h900;
        tick(); tick();
        total++;
        if (debug_halt_req !== 1'b0 || debug_mode !== 1'b1 || dpc !== 32'h200)
            $display("FAIL debug_ignores: got req%b dm%b dpc=%h want 0 1 200",
                     debug_halt_req, debug_mode, dpc);
        else passed++;
        // dret with haltreq still high re-enters WAIT_BND.
        idle(); exe_valid = 1; dret = 1; haltreq = 1;
        tick();
        dret = 0; exe_valid = 0;
        tick();
        total++;
        if (debug_mode !== 1'b0 || debug_halt_req !== 1'b0 || cause !== 3'd3)
            $display("FAIL resume_rehalt_wait: got dm%b req%b cause=%0d want 0 0 3",
                     debug_mode, debug_halt_req, cause);
        else passed++;
        exe_valid = 1; exe_pc = 32'h400; exe_npc = 32'h404;
        tick();
        total++;
        if (debug_halt_req !== 1'b1 || dpc !== 32'h404)
            $display("FAIL resume_rehalt_enter: got req%b dpc=%h want 1 404", debug_halt_req, dpc);
        else passed++;
        idle();
        tick();
        exit_debug();
    endtask

    task automatic test_stall_timeout();
        idle(); haltreq = 1; exe_valid = 1; exe_stall = 1;
        tick();
        for (int i = 0; i < 254; i++) tick();
        total++;
        if (halt_timeout !== 1'b0 || debug_halt_req !== 1'b0)
            $display("FAIL timeout_early: got to%b req%b want 0 0", halt_timeout, debug_halt_req);
        else passed++;
        tick();
        total++;
        if (halt_timeout !== 1'b1) $display("FAIL timeout_rise: got %b want 1", halt_timeout);
        else passed++;
        haltreq = 0;
        for (int i = 0; i < 45; i++) tick();
        total++;
        if (halt_timeout !== 1'b1 || debug_halt_req !== 1'b0)
            $display("FAIL timeout_sticky: got to%b req%b want 1 0", halt_timeout, debug_halt_req);
        else passed++;
        exe_stall = 0; exe_pc = 32'h500; exe_npc = 32'h504;
        tick();
        total++;
        if (debug_halt_req !== 1'b1 || halt_timeout !== 1'b0 || dpc !== 32'h504 || cause !== 3'd3)
            $display("FAIL timeout_release: got req%b to%b dpc=%h cause=%0d want 1 0 504 3",
                     debug_halt_req, halt_timeout, dpc, cause);
        else passed++;
        idle();
        tick();
    endtask

    task automatic test_single_step();
        idle(); exe_valid = 1; dret = 1; step = 1;
        tick();
        total++;
        if (resumeack !== 1'b1) $display("FAIL step_resumeack: got %b want 1", resumeack);
        else passed++;
        dret = 0; exe_valid = 0;
        tick();
        total++;
        if (resumeack !== 1'b0 || debug_mode !== 1'b0 || debug_halt_req !== 1'b0)
            $display("FAIL step_state: got ra%b dm%b req%b want 0 0 0", resumeack, debug_mode, debug_halt_req);
        else passed++;
        exe_valid = 1; exe_pc = 32'h304; exe_npc = 32'h308;
        tick();
        total++;
        if (debug_halt_req !== 1'b1 || cause !== 3'd4 || dpc !== 32'h308)
            $display("FAIL step_enter: got req%b cause=%0d dpc=%h want 1 4 308", debug_halt_req, cause, dpc);
        else passed++;
        idle();
        tick();
        // Second step with haltreq at the boundary: haltreq outranks step.
        exe_valid = 1; dret = 1; step = 1;
        tick();
        dret = 0; exe_valid = 0;
        tick();
        exe_valid = 1; haltreq = 1; exe_pc = 32'h308; exe_npc = 32'h30c;
        tick();
        total++;
        if (debug_halt_req !== 1'b1 || cause !== 3'd3 || dpc !== 32'h30c)
            $display("FAIL step_haltreq_prio: got req%b cause=%0d dpc=%h want 1 3 30c",
                     debug_halt_req, cause, dpc);
        else passed++;
        idle();
        tick();
        exit_debug();
    endtask

    task automatic test_flush_skip();
        idle(); haltreq = 1;
        tick();
        exe_valid = 1; exe_flush = 1; exe_pc = 32'h5fc; exe_npc = 32'h600;
        tick();
        total++;
        if (debug_halt_req !== 1'b0) $display("FAIL flush_no_pulse: got %b want 0", debug_halt_req);
        else passed++;
        exe_flush = 0; exe_pc = 32'h604; exe_npc = 32'h608;
        tick();
        total++;
        if (debug_halt_req !== 1'b1 || dpc !== 32'h608)
            $display("FAIL flush_next: got req%b dpc=%h want 1 608", debug_halt_req, dpc);
        else passed++;
        idle();
        tick();
    endtask

    task automatic test_mid_reset();
        // Currently in DEBUG.
        #2 rst_n = 0;
        #1;
        total++;
        if (debug_mode !== 1'b0 || dpc !== 32'h0 || cause !== 3'd0)
            $display("FAIL reset_in_debug: got dm%b dpc=%h cause=%0d want 0 0 0", debug_mode, dpc, cause);
        else passed++;
        tick();
        rst_n = 1;
        idle(); haltreq = 1;
        tick();
        exe_valid = 1; exe_npc = 32'h704;
        tick();
        #2 rst_n = 0;
        #1;
        total++;
        if (debug_halt_req !== 1'b0 || dpc_we !== 1'b0 || dpc !== 32'h0)
            $display("FAIL reset_in_enter: got req%b we%b dpc=%h want 0 0 0", debug_halt_req, dpc_we, dpc);
        else passed++;
        idle();
        tick();
        rst_n = 1;
        tick(); tick();
        total++;
        if (debug_halt_req !== 1'b0 || debug_mode !== 1'b0)
            $display("FAIL reset_no_pulse: got req%b dm%b want 0 0", debug_halt_req, debug_mode);
        else passed++;
        haltreq = 1;
        tick();
        exe_valid = 1; exe_pc = 32'h800; exe_npc = 32'h804;
        tick();
        total++;
        if (debug_halt_req !== 1'b1 || dpc !== 32'h804 || cause !== 3'd3)
            $display("FAIL reset_then_halt: got req%b dpc=%h cause=%0d want 1 804 3",
                     debug_halt_req, dpc, cause);
        else passed++;
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_haltreq();
        test_ebreak();
        test_stall_timeout();
        test_single_step();
        test_flush_skip();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
